// File: rtl/rpn_wnn_seq_num_repo_pkg.sv
// Shared control-API definitions for the WNN sequence-number repository:
// message codes, tdata field layout, tuser sub-field layout and FSM states.
package rpn_wnn_seq_num_repo_pkg;

    localparam int RPN_TYPE_OFF = 0;
    localparam int RPN_TYPE_W   = 8;
    localparam int RPN_SEQ_OFF  = 32;
    localparam int RPN_SEQ_W    = 32;

    localparam int RPN_TUSER_IP_OFF    = 0;
    localparam int RPN_TUSER_DPORT_OFF = 32;
    localparam int RPN_TUSER_SPORT_OFF = 48;
    localparam int RPN_TUSER_PORT_W    = 16;

    typedef enum logic [RPN_TYPE_W-1:0] {
        OUTGOING_SEQ_NUM_REQUEST = 8'h01,
        OUTGOING_SEQ_NUM_REPLY   = 8'h02,
        OUTGOING_SEQ_NUM_WRITE   = 8'h03,
        OUTGOING_SEQ_NUM_BRESP   = 8'h04,
        INCOMING_SEQ_NUM_REQUEST = 8'h05,
        INCOMING_SEQ_NUM_REPLY   = 8'h06,
        INCOMING_SEQ_NUM_WRITE   = 8'h07,
        INCOMING_SEQ_NUM_BRESP   = 8'h08
    } rpn_msg_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_LOOKUP,
        ST_RESPOND
    } repo_state_e;

endpackage

// File: rtl/rpn_wnn_seq_num_repo_if.sv
// AXI-Stream bundle used for both the splitter input and the bridge output.
interface rpn_wnn_seq_num_repo_if #(
    parameter int AXIS_DATA_WIDTH  = 64,
    parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_TDEST_WIDTH = 8,
    parameter int AXIS_TUSER_WIDTH = 64
);
    logic                        tvalid;
    logic                        tready;
    logic [AXIS_DATA_WIDTH-1:0]  tdata;
    logic [AXIS_KEEP_WIDTH-1:0]  tkeep;
    logic [AXIS_TDEST_WIDTH-1:0] tid;
    logic [AXIS_TDEST_WIDTH-1:0] tdest;
    logic [AXIS_TUSER_WIDTH-1:0] tuser;
    logic                        tlast;

    modport master (output tvalid, tdata, tkeep, tid, tdest, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tid, tdest, tuser, tlast, output tready);
endinterface

// File: rtl/rpn_wnn_seq_num_repo_table.sv
// Single-port sequence-number table with registered read and a per-entry valid bit.
// Contents are never reset; an entry without its valid bit reads as zero.
module rpn_wnn_seq_num_table #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_ap_rst_n,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        valid_d = valid_q;
        rdata_d = rdata_q;
        if (i_en) begin
            if (i_we) valid_d[i_addr] = 1'b1;
            else      rdata_d = valid_q[i_addr] ? mem[i_addr] : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) valid_q <= '0;
        else             valid_q <= valid_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_en && i_we) mem[i_addr] <= i_wdata;
        rdata_q <= rdata_d;
    end

    assign o_rdata = rdata_q;
endmodule

// File: rtl/rpn_wnn_seq_num_repo.sv
// WNN sequence-number repository: serves read/write requests for outgoing and
// incoming per-kernel sequence numbers, one message in flight at a time.
module rpn_wnn_seq_num_repo
    import rpn_wnn_seq_num_repo_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH    = 64,
    parameter int AXIS_KEEP_WIDTH    = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_TDEST_WIDTH   = 8,
    parameter int AXIS_TUSER_WIDTH   = 64,
    parameter int RPN_MSG_TYPE_WIDTH = RPN_TYPE_W,
    parameter int SEQ_NUM_OFFSET     = RPN_SEQ_OFF,
    parameter int SEQ_NUM_WIDTH      = RPN_SEQ_W
) (
    input  logic                           i_clk,
    input  logic                           i_ap_rst_n,
    rpn_wnn_seq_num_repo_if.slave          from_splitter,
    rpn_wnn_seq_num_repo_if.master         to_network_bridge,
    output logic [15:0]                    o_drop_count
);
    repo_state_e state_q, state_d;
    logic        rdy_q, rdy_d;
    logic [15:0] drop_q, drop_d;

    logic                          rsp_vld_q, rsp_vld_d;
    logic [AXIS_DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic [AXIS_TDEST_WIDTH-1:0]   rsp_tid_q, rsp_tid_d, rsp_tdest_q, rsp_tdest_d;
    logic [AXIS_TUSER_WIDTH-1:0]   rsp_user_q, rsp_user_d;

    logic [RPN_MSG_TYPE_WIDTH-1:0] cap_type_q, cap_type_d, eff_type, rep_type;
    logic [SEQ_NUM_WIDTH-1:0]      cap_seq_q, cap_seq_d, eff_seq, rep_seq;
    logic [AXIS_TDEST_WIDTH-1:0]   cap_tid_q, cap_tid_d, eff_tid;
    logic [AXIS_TDEST_WIDTH-1:0]   cap_tdest_q, cap_tdest_d, eff_tdest;
    logic [AXIS_TUSER_WIDTH-1:0]   cap_user_q, cap_user_d, eff_user;

    logic                     accept, rep_load, out_en, in_en, tbl_we;
    logic [SEQ_NUM_WIDTH-1:0] out_rdata, in_rdata;
    logic                     unused_in;

    assign accept    = rdy_q && from_splitter.tvalid;
    assign unused_in = ^{from_splitter.tkeep, from_splitter.tdata};

    // Header fields come straight off the bus on a first beat, otherwise from the capture.
    always_comb begin
        eff_type  = cap_type_q;
        eff_seq   = cap_seq_q;
        eff_tid   = cap_tid_q;
        eff_tdest = cap_tdest_q;
        eff_user  = cap_user_q;
        if (state_q == ST_IDLE) begin
            eff_type  = from_splitter.tdata[RPN_TYPE_OFF +: RPN_MSG_TYPE_WIDTH];
            eff_seq   = from_splitter.tdata[SEQ_NUM_OFFSET +: SEQ_NUM_WIDTH];
            eff_tid   = from_splitter.tid;
            eff_tdest = from_splitter.tdest;
            eff_user  = from_splitter.tuser;
        end
    end

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        rsp_vld_d   = rsp_vld_q;
        cap_type_d  = cap_type_q;
        cap_seq_d   = cap_seq_q;
        cap_tid_d   = cap_tid_q;
        cap_tdest_d = cap_tdest_q;
        cap_user_d  = cap_user_q;
        rep_load    = 1'b0;
        rep_type    = '0;
        rep_seq     = '0;
        out_en      = 1'b0;
        in_en       = 1'b0;
        tbl_we      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DRAIN: begin
                if (accept && state_q == ST_IDLE) begin
                    cap_type_d  = eff_type;
                    cap_seq_d   = eff_seq;
                    cap_tid_d   = eff_tid;
                    cap_tdest_d = eff_tdest;
                    cap_user_d  = eff_user;
                end
                if (accept && !from_splitter.tlast) begin
                    state_d = ST_DRAIN;
                end else if (accept) begin
                    case (eff_type)
                        OUTGOING_SEQ_NUM_REQUEST: begin out_en = 1'b1; state_d = ST_LOOKUP; end
                        INCOMING_SEQ_NUM_REQUEST: begin in_en  = 1'b1; state_d = ST_LOOKUP; end
                        OUTGOING_SEQ_NUM_WRITE, INCOMING_SEQ_NUM_WRITE: begin
                            out_en   = (eff_type == OUTGOING_SEQ_NUM_WRITE);
                            in_en    = (eff_type == INCOMING_SEQ_NUM_WRITE);
                            tbl_we   = 1'b1;
                            rep_load = 1'b1;
                            rep_type = (eff_type == OUTGOING_SEQ_NUM_WRITE) ?
                                       OUTGOING_SEQ_NUM_BRESP : INCOMING_SEQ_NUM_BRESP;
                            rep_seq  = eff_seq;
                            state_d  = ST_RESPOND;
                        end
                        default: begin
                            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_LOOKUP: begin
                rep_load = 1'b1;
                rep_type = (cap_type_q == OUTGOING_SEQ_NUM_REQUEST) ?
                           OUTGOING_SEQ_NUM_REPLY : INCOMING_SEQ_NUM_REPLY;
                rep_seq  = (cap_type_q == OUTGOING_SEQ_NUM_REQUEST) ? out_rdata : in_rdata;
                state_d  = ST_RESPOND;
            end
            ST_RESPOND: begin
                if (to_network_bridge.tready) begin
                    rsp_vld_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (rep_load) rsp_vld_d = 1'b1;
        rdy_d = (state_d == ST_IDLE) || (state_d == ST_DRAIN);
    end

    // Reply payload: addresses swap roles and the tuser port fields trade places.
    always_comb begin
        rsp_data_d  = rsp_data_q;
        rsp_tid_d   = rsp_tid_q;
        rsp_tdest_d = rsp_tdest_q;
        rsp_user_d  = rsp_user_q;
        if (rep_load) begin
            rsp_data_d = '0;
            rsp_data_d[RPN_TYPE_OFF +: RPN_MSG_TYPE_WIDTH] = rep_type;
            rsp_data_d[SEQ_NUM_OFFSET +: SEQ_NUM_WIDTH]    = rep_seq;
            rsp_tid_d   = eff_tdest;
            rsp_tdest_d = eff_tid;
            rsp_user_d  = eff_user;
            rsp_user_d[RPN_TUSER_DPORT_OFF +: RPN_TUSER_PORT_W] = eff_user[RPN_TUSER_SPORT_OFF +: RPN_TUSER_PORT_W];
            rsp_user_d[RPN_TUSER_SPORT_OFF +: RPN_TUSER_PORT_W] = eff_user[RPN_TUSER_DPORT_OFF +: RPN_TUSER_PORT_W];
        end
    end

    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            state_q     <= ST_IDLE;
            rdy_q       <= 1'b0;
            drop_q      <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tid_q   <= '0;
            rsp_tdest_q <= '0;
            rsp_user_q  <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            drop_q      <= drop_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tid_q   <= rsp_tid_d;
            rsp_tdest_q <= rsp_tdest_d;
            rsp_user_q  <= rsp_user_d;
        end
    end

    always_ff @(posedge i_clk) begin
        cap_type_q  <= cap_type_d;
        cap_seq_q   <= cap_seq_d;
        cap_tid_q   <= cap_tid_d;
        cap_tdest_q <= cap_tdest_d;
        cap_user_q  <= cap_user_d;
    end

    rpn_wnn_seq_num_table #(.ADDR_W(AXIS_TDEST_WIDTH), .DATA_W(SEQ_NUM_WIDTH)) u_out_tbl (
        .i_clk(i_clk), .i_ap_rst_n(i_ap_rst_n), .i_en(out_en), .i_we(tbl_we),
        .i_addr(eff_tid), .i_wdata(eff_seq), .o_rdata(out_rdata)
    );

    rpn_wnn_seq_num_table #(.ADDR_W(AXIS_TDEST_WIDTH), .DATA_W(SEQ_NUM_WIDTH)) u_in_tbl (
        .i_clk(i_clk), .i_ap_rst_n(i_ap_rst_n), .i_en(in_en), .i_we(tbl_we),
        .i_addr(eff_tid), .i_wdata(eff_seq), .o_rdata(in_rdata)
    );

    assign from_splitter.tready    = rdy_q;
    assign to_network_bridge.tvalid = rsp_vld_q;
    assign to_network_bridge.tdata  = rsp_data_q;
    assign to_network_bridge.tkeep  = '1;
    assign to_network_bridge.tid    = rsp_tid_q;
    assign to_network_bridge.tdest  = rsp_tdest_q;
    assign to_network_bridge.tuser  = rsp_user_q;
    assign to_network_bridge.tlast  = 1'b1;
    assign o_drop_count             = drop_q;
endmodule

// File: tb/tb_rpn_wnn_seq_num_repo.sv
// Directed bench for the sequence-number repository with a reply scoreboard.
module tb_rpn_wnn_seq_num_repo;
    import rpn_wnn_seq_num_repo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] drop;

    always #5 clk = ~clk;

    rpn_wnn_seq_num_repo_if s_if ();
    rpn_wnn_seq_num_repo_if m_if ();

    rpn_wnn_seq_num_repo dut (
        .i_clk(clk), .i_ap_rst_n(rst_n),
        .from_splitter(s_if), .to_network_bridge(m_if), .o_drop_count(drop)
    );

    typedef struct {
        logic [63:0] tdata;
        logic [7:0]  tid;
        logic [7:0]  tdest;
    } exp_t;

    localparam logic [63:0] TUSER_IN  = 64'hBBBB_ACAC_C0A8_0001;
    localparam logic [63:0] TUSER_OUT = 64'hACAC_BBBB_C0A8_0001;
    localparam logic [7:0]  SRC_DEST  = 8'hAB;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_drop = 0;
    logic [31:0] out_m [256];
    logic [31:0] in_m  [256];
    bit          out_v [256];
    bit          in_v  [256];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] rtype, input logic [31:0] seq, input logic [7:0] tid);
        exp_t e;
        e.tdata = {seq, 24'h0, rtype};
        e.tid   = SRC_DEST;
        e.tdest = tid;
        sb.push_back(e);
    endtask

    task automatic model(input logic [7:0] typ, input logic [7:0] tid, input logic [31:0] seq);
        case (typ)
            OUTGOING_SEQ_NUM_REQUEST: push_exp(OUTGOING_SEQ_NUM_REPLY, out_v[tid] ? out_m[tid] : 32'h0, tid);
            INCOMING_SEQ_NUM_REQUEST: push_exp(INCOMING_SEQ_NUM_REPLY, in_v[tid] ? in_m[tid] : 32'h0, tid);
            OUTGOING_SEQ_NUM_WRITE: begin
                out_m[tid] = seq; out_v[tid] = 1'b1; push_exp(OUTGOING_SEQ_NUM_BRESP, seq, tid);
            end
            INCOMING_SEQ_NUM_WRITE: begin
                in_m[tid] = seq; in_v[tid] = 1'b1; push_exp(INCOMING_SEQ_NUM_BRESP, seq, tid);
            end
            default: exp_drop++;
        endcase
    endtask

    // Later beats carry a different type/tid/tuser so only first-beat decode is correct.
    task automatic send_msg(input logic [7:0] typ, input logic [7:0] tid, input logic [31:0] seq, input int nbeats);
        model(typ, tid, seq);
        for (int b = 0; b < nbeats; b++) begin
            int n = 0;
            s_if.tvalid = 1'b1;
            s_if.tkeep  = 8'hFF;
            s_if.tdata  = (b == 0) ? {seq, 24'h0, typ} :
                          {32'hA5A5_0000 + 32'(b), 24'h0, 8'(OUTGOING_SEQ_NUM_REQUEST)};
            s_if.tid    = (b == 0) ? tid : 8'h5A;
            s_if.tdest  = (b == 0) ? SRC_DEST : 8'h3C;
            s_if.tuser  = (b == 0) ? TUSER_IN : 64'h1111_2222_3333_4444;
            s_if.tlast  = (b == nbeats - 1);
            while (s_if.tready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
            if (n >= 40) chk("in_tready_timeout", {63'h0, s_if.tready}, 64'h1);
            @(negedge clk);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic recv(input string tag, input int stall);
        int   n = 0;
        exp_t e;
        while (m_if.tvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_tvalid"}, {63'h0, m_if.tvalid}, 64'h1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'h0, 64'h1);
        end else begin
            e = sb.pop_front();
            for (int i = 0; i < stall; i++) begin
                chk({tag, "_stall_vld"},  {63'h0, m_if.tvalid}, 64'h1);
                chk({tag, "_stall_data"}, m_if.tdata, e.tdata);
                chk({tag, "_stall_inrdy"}, {63'h0, s_if.tready}, 64'h0);
                @(negedge clk);
            end
            chk({tag, "_tdata"}, m_if.tdata, e.tdata);
            chk({tag, "_tid"},   {56'h0, m_if.tid}, {56'h0, e.tid});
            chk({tag, "_tdest"}, {56'h0, m_if.tdest}, {56'h0, e.tdest});
            chk({tag, "_tuser"}, m_if.tuser, TUSER_OUT);
            chk({tag, "_tkeep_tlast"}, {55'h0, m_if.tkeep, m_if.tlast}, {55'h0, 8'hFF, 1'b1});
        end
        m_if.tready = 1'b1;
        @(negedge clk);
        m_if.tready = 1'b0;
        chk({tag, "_tvalid_low"}, {63'h0, m_if.tvalid}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin out_v[i] = 1'b0; in_v[i] = 1'b0; end
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tid = '0;
        s_if.tdest = '0; s_if.tuser = '0; s_if.tlast = 1'b0; m_if.tready = 1'b0;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_tready",  {63'h0, s_if.tready}, 64'h0);
        chk("rst_out_tvalid", {63'h0, m_if.tvalid}, 64'h0);
        chk("rst_drop",       {48'h0, drop}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_tready", {63'h0, s_if.tready}, 64'h1);

        // Unwritten entry reads zero, with two-cycle request latency.
        send_msg(OUTGOING_SEQ_NUM_REQUEST, 8'hCC, 32'h0, 1);
        chk("req_lat1", {63'h0, m_if.tvalid}, 64'h0);
        @(negedge clk);
        chk("req_lat2", {63'h0, m_if.tvalid}, 64'h1);
        recv("out_req_empty", 0);

        send_msg(OUTGOING_SEQ_NUM_WRITE, 8'hCC, 32'h1234_5678, 1);
        chk("wr_lat1", {63'h0, m_if.tvalid}, 64'h1);
        recv("out_wr", 0);
        send_msg(OUTGOING_SEQ_NUM_REQUEST, 8'hCC, 32'h0, 1);
        recv("out_req_written", 0);
        send_msg(INCOMING_SEQ_NUM_REQUEST, 8'hCC, 32'h0, 1);
        recv("in_req_empty", 0);

        // Backpressure on the reply.
        send_msg(OUTGOING_SEQ_NUM_REQUEST, 8'hCC, 32'h0, 1);
        recv("backpressure", 10);

        // Unknown type dropped, then a three-beat write.
        send_msg(8'hFF, 8'h22, 32'h9999_0000, 1);
        chk("drop_count1", {48'h0, drop}, 64'(exp_drop));
        repeat (3) @(negedge clk);
        chk("drop_no_reply", {63'h0, m_if.tvalid}, 64'h0);
        send_msg(OUTGOING_SEQ_NUM_WRITE, 8'h10, 32'hDEAD_BEEF, 3);
        recv("multibeat_wr", 0);
        repeat (3) @(negedge clk);
        chk("multibeat_single", {63'h0, m_if.tvalid}, 64'h0);
        chk("drop_count_after", {48'h0, drop}, 64'h1);
        send_msg(OUTGOING_SEQ_NUM_REQUEST, 8'h10, 32'h0, 1);
        recv("multibeat_rd", 0);

        // All-ones sequence numbers at both ends of the index range.
        send_msg(OUTGOING_SEQ_NUM_WRITE, 8'h00, 32'hFFFF_FFFF, 1);
        recv("ones_wr_00", 0);
        send_msg(INCOMING_SEQ_NUM_WRITE, 8'hFF, 32'hFFFF_FFFF, 1);
        recv("ones_wr_ff", 0);
        send_msg(OUTGOING_SEQ_NUM_REQUEST, 8'h00, 32'h0, 1);
        recv("ones_rd_00", 0);
        send_msg(INCOMING_SEQ_NUM_REQUEST, 8'hFF, 32'h0, 1);
        recv("ones_rd_ff", 0);

        // Reset while a reply is pending.
        send_msg(INCOMING_SEQ_NUM_WRITE, 8'h44, 32'h0BAD_F00D, 1);
        chk("pre_rst_tvalid", {63'h0, m_if.tvalid}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_tvalid", {63'h0, m_if.tvalid}, 64'h0);
        chk("rst_mid_inrdy",  {63'h0, s_if.tready}, 64'h0);
        chk("rst_mid_drop",   {48'h0, drop}, 64'h0);
        void'(sb.pop_front());
        for (int i = 0; i < 256; i++) begin out_v[i] = 1'b0; in_v[i] = 1'b0; end
        exp_drop = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_in_tready", {63'h0, s_if.tready}, 64'h1);
        send_msg(INCOMING_SEQ_NUM_REQUEST, 8'h44, 32'h0, 1);
        recv("post_rst_rd_44", 0);
        send_msg(OUTGOING_SEQ_NUM_REQUEST, 8'hCC, 32'h0, 1);
        recv("post_rst_rd_cc", 0);
        chk("sb_drained", 64'(sb.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
